// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-port Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int N_REQ = 2;

  // Grant state that belongs to a requester index.
  function automatic arb_state_t gnt_of(input logic port);
    return port ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle carrying its own clock and reset.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic [31:0] dat_sm;

  modport master (
    input  clk, rst, ack, dat_sm,
    output cyc, stb, we, adr, sel, dat_ms, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output ack, dat_sm
  );

endinterface

// File: rtl/wshb_mux.sv
// Combinational routing of the owner's request onto the shared port and of ack back to it.
module wshb_mux
  import wshb_arb_pkg::*;
(
  input arb_state_t    owner,
  wshb_if.slave        s0,
  wshb_if.slave        s1,
  wshb_if.master       m
);

  // Route request signals from the current owner; bus quiet and acks low otherwise.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    m.cyc    = 1'b0;
    m.stb    = 1'b0;
    m.we     = 1'b0;
    m.adr    = '0;
    m.sel    = '0;
    m.dat_ms = '0;
    m.cti    = '0;
    m.bte    = '0;
    s0.ack   = 1'b0;
    s1.ack   = 1'b0;
    case (owner)
      ARB_GNT0: begin
        m.cyc    = s0.cyc;
        m.stb    = s0.stb;
        m.we     = s0.we;
        m.adr    = s0.adr;
        m.sel    = s0.sel;
        m.dat_ms = s0.dat_ms;
        m.cti    = s0.cti;
        m.bte    = s0.bte;
        s0.ack   = m.ack;
      end
      ARB_GNT1: begin
        m.cyc    = s1.cyc;
        m.stb    = s1.stb;
        m.we     = s1.we;
        m.adr    = s1.adr;
        m.sel    = s1.sel;
        m.dat_ms = s1.dat_ms;
        m.cti    = s1.cti;
        m.bte    = s1.bte;
        s1.ack   = m.ack;
      end
      default: ;
    endcase
  end

  // Read data is harmless to broadcast; only the owner sees an ack.
  assign s0.dat_sm = m.dat_sm;
  assign s1.dat_sm = m.dat_sm;

endmodule

// File: rtl/wshb_arbiter.sv
// Round-robin arbiter for two Wishbone requesters sharing one memory port.
// A grant lasts until the owner drops cyc, or until MAX_BURST acks while the
// other port waits, so an always-busy reader cannot starve the writer.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  wshb_if.slave  wshb_ifs_0,
  wshb_if.slave  wshb_ifs_1,
  wshb_if.master wshb_ifm
);

  localparam int              CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0]   MAX_CNT   = CW'(MAX_BURST);

  logic             clk;
  logic             rst;
  arb_state_t       owner;
  logic             rr_last;
  logic [CW-1:0]    burst_cnt;
  logic [N_REQ-1:0] req;
  logic             cur;

  assign clk = wshb_ifm.clk;
  assign rst = wshb_ifm.rst;
  assign req = {wshb_ifs_1.cyc, wshb_ifs_0.cyc};
  assign cur = (owner == ARB_GNT1);

  // Ownership FSM: grants only from IDLE, hands over on owner release or at a burst-limit ack.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      owner     <= ARB_IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      case (owner)
        ARB_IDLE: begin
          burst_cnt <= '0;
          if (req[0] && req[1]) owner <= gnt_of(!rr_last);
          else if (req[0])      owner <= ARB_GNT0;
          else if (req[1])      owner <= ARB_GNT1;
        end
        ARB_GNT0, ARB_GNT1: begin
          if (!req[cur]) begin
            owner     <= req[!cur] ? gnt_of(!cur) : ARB_IDLE;
            rr_last   <= cur;
            burst_cnt <= '0;
          end else if (wshb_ifm.ack && req[!cur] && burst_cnt == LAST_BEAT) begin
            owner     <= gnt_of(!cur);
            rr_last   <= cur;
            burst_cnt <= '0;
          end else if (wshb_ifm.ack && burst_cnt != MAX_CNT) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: owner <= ARB_IDLE;
      endcase
    end
  end

  wshb_mux u_mux (
    .owner (owner),
    .s0    (wshb_ifs_0),
    .s1    (wshb_ifs_1),
    .m     (wshb_ifm)
  );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with MAX_BURST=4 and a slave acking every 2nd cycle.
module tb_wshb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wshb_if ifs0 (.clk(clk), .rst(rst));
  wshb_if ifs1 (.clk(clk), .rst(rst));
  wshb_if ifm  (.clk(clk), .rst(rst));

  wshb_arbiter #(.MAX_BURST(4)) dut (
    .wshb_ifs_0 (ifs0),
    .wshb_ifs_1 (ifs1),
    .wshb_ifm   (ifm)
  );

  // Memory slave model: registered ack, one ack every second cycle while requested.
  logic        s_ack;
  logic [31:0] s_data;

  always @(posedge clk or posedge rst) begin
    if (rst) s_ack <= 1'b0;
    else     s_ack <= ifm.cyc & ifm.stb & ~s_ack;
  end

  assign ifm.ack    = s_ack;
  assign ifm.dat_sm = s_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: requesters consume the ack seen before the edge, then return to the sampling point.
  task automatic step();
    logic a0, a1;
    a0 = ifs0.ack;
    a1 = ifs1.ack;
    @(posedge clk);
    #1;
    if (a0) ifs0.adr = ifs0.adr + 32'd4;
    if (a1) ifs1.adr = ifs1.adr + 32'd4;
    @(negedge clk);
  endtask

  task automatic set_req(input logic c0, input logic [31:0] a0,
                         input logic c1, input logic [31:0] a1);
    ifs0.cyc = c0; ifs0.stb = c0; ifs0.adr = a0;
    ifs1.cyc = c1; ifs1.stb = c1; ifs1.adr = a1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g, w, beats;
    logic own1;
    logic [31:0] exp_adr;

    ifs0.we = 1'b1; ifs0.sel = 4'hF; ifs0.dat_ms = 32'hAAAA_0000; ifs0.cti = 3'd0; ifs0.bte = 2'd0;
    ifs1.we = 1'b0; ifs1.sel = 4'h3; ifs1.dat_ms = 32'h5555_1111; ifs1.cti = 3'd2; ifs1.bte = 2'd1;
    s_data = 32'hCAFE_F00D;

    // Reset held with both requesting: bus must stay released.
    set_req(1'b1, 32'h0, 1'b1, 32'h1000);
    @(negedge clk);
    @(negedge clk);
    check("t1_rst_cyc",  32'(ifm.cyc), 32'd0);
    check("t1_rst_adr",  ifm.adr, 32'd0);
    check("t1_rst_ack0", 32'(ifs0.ack), 32'd0);
    check("t1_rst_ack1", 32'(ifs1.ack), 32'd0);

    // Both requesting from IDLE: 8-cycle grants (4 acks), port 0 first.
    rst = 1'b0;
    step();
    check("t1_gnt0_cyc", 32'(ifm.cyc), 32'd1);
    for (int c = 0; c < 32; c++) begin
      g     = c / 8;
      w     = c % 8;
      own1  = (g % 2) == 1;
      beats = (g / 2) * 4 + w / 2;
      exp_adr = own1 ? 32'h1000 + 32'(4 * beats) : 32'(4 * beats);
      check($sformatf("t3_adr_c%0d", c),  ifm.adr, exp_adr);
      check($sformatf("t3_ack0_c%0d", c), 32'(ifs0.ack), 32'(!own1 && (w % 2) == 1));
      check($sformatf("t3_ack1_c%0d", c), 32'(ifs1.ack), 32'(own1 && (w % 2) == 1));
      check($sformatf("t3_we_c%0d", c),   32'(ifm.we), own1 ? 32'd0 : 32'd1);
      if (w == 0) begin
        check($sformatf("t3_dat_c%0d", c), ifm.dat_ms, own1 ? 32'h5555_1111 : 32'hAAAA_0000);
        check($sformatf("t3_cti_c%0d", c), 32'(ifm.cti), own1 ? 32'd2 : 32'd0);
      end
      if (c == 1) begin
        check("t3_dsm0", ifs0.dat_sm, 32'hCAFE_F00D);
        check("t3_dsm1", ifs1.dat_sm, 32'hCAFE_F00D);
      end
      step();
    end

    // Port 0 alone, drops cyc after two acks -> IDLE; then a tie goes to port 1.
    rst = 1'b1;
    set_req(1'b1, 32'h0, 1'b0, 32'h1000);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
    check("t4_adr_after2", ifm.adr, 32'h8);
    ifs0.cyc = 1'b0; ifs0.stb = 1'b0;
    step();
    check("t4_idle_cyc",  32'(ifm.cyc), 32'd0);
    check("t4_idle_adr",  ifm.adr, 32'd0);
    check("t4_idle_ack0", 32'(ifs0.ack), 32'd0);
    check("t4_idle_cnt",  32'(dut.burst_cnt), 32'd0);
    ifs0.cyc = 1'b1; ifs0.stb = 1'b1; ifs1.cyc = 1'b1; ifs1.stb = 1'b1;
    step();
    check("t4_rr_adr", ifm.adr, 32'h1000);
    check("t4_rr_we",  32'(ifm.we), 32'd0);

    // Port 0 drops cyc on its 4th ack while port 1 waits.
    rst = 1'b1;
    set_req(1'b1, 32'h0, 1'b1, 32'h2000);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    check("t5_ack4",     32'(ifs0.ack), 32'd1);
    check("t5_adr4",     ifm.adr, 32'hC);
    ifs0.cyc = 1'b0; ifs0.stb = 1'b0;
    check("t5_ack_keep", 32'(ifs0.ack), 32'd1);
    step();
    check("t5_gnt1_adr",  ifm.adr, 32'h2000);
    check("t5_gnt1_cyc",  32'(ifm.cyc), 32'd1);
    check("t5_gnt1_ack0", 32'(ifs0.ack), 32'd0);
    check("t5_gnt1_ack1", 32'(ifs1.ack), 32'd0);
    step();
    check("t5_p1_ack",    32'(ifs1.ack), 32'd1);

    // Port 1 alone, then reset asserted while its ack is on the bus.
    rst = 1'b1;
    s_data = 32'h1234_5678;
    set_req(1'b0, 32'h0, 1'b1, 32'h10);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t2_adr",      ifm.adr, 32'h10);
    check("t2_ack1_0",   32'(ifs1.ack), 32'd0);
    step();
    check("t2_ack1",     32'(ifs1.ack), 32'd1);
    check("t2_ack0",     32'(ifs0.ack), 32'd0);
    check("t2_dsm1",     ifs1.dat_sm, 32'h1234_5678);
    step();
    check("t2_adr_next", ifm.adr, 32'h14);
    step();
    check("t6_pre_ack1", 32'(ifs1.ack), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_cyc",  32'(ifm.cyc), 32'd0);
    check("t6_rst_ack1", 32'(ifs1.ack), 32'd0);
    check("t6_rst_adr",  ifm.adr, 32'd0);
    @(negedge clk);
    check("t6_hold_ack1", 32'(ifs1.ack), 32'd0);
    rst = 1'b0;
    step();
    check("t6_regnt_adr",  ifm.adr, 32'h14);
    check("t6_regnt_ack1", 32'(ifs1.ack), 32'd0);
    step();
    check("t6_reack1",     32'(ifs1.ack), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
